rv32i_decode_stage: RTL and testbench

//  Decodes the RV32I base-opcode, funct3/funct7 and immediate encodings

---
 rtl/ALU_FNS.sv | 20 ++
 rtl/LOAD_STORE_FNS.sv | 12 +
 rtl/rv32i_decode_pkg.sv | 32 +++
 rtl/rv32i_opcodes.sv | 18 +
 rtl/rv32i_imm_gen.sv | 38 +++
 rtl/rv32i_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 321 ++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/ALU_FNS.sv
// ALU function encodings carried in funct7/funct3 of OP and OP_IMM.
package ALU_FNS;

    typedef enum logic [6:0] {
        ADD_SRL = 7'b0000000,
        SUB_SRA = 7'b0100000
    } alu_funct7_t;

    typedef enum logic [2:0] {
        ADD_SUB = 3'd0,
        SLL     = 3'd1,
        SLT     = 3'd2,
        SLTU    = 3'd3,
        XOR     = 3'd4,
        SRL_SRA = 3'd5,
        OR      = 3'd6,
        AND     = 3'd7
    } alu_funct3_t;

endpackage

// File: rtl/LOAD_STORE_FNS.sv
// Load/store width encodings carried in funct3.
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd4,
        HALF_U = 3'd5
    } ls_funct3_t;

endpackage

// File: rtl/rv32i_decode_pkg.sv
// Decode-stage types: instruction format tag, OP_IMM shift selectors, decoded field bundle.
package rv32i_decode_pkg;

    import rv32i_opcodes::*;
    import ALU_FNS::*;
    import LOAD_STORE_FNS::*;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } inst_fmt_t;

    localparam logic [2:0] Funct3Slli     = 3'b001;
    localparam logic [2:0] Funct3SrliSrai = 3'b101;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        inst_fmt_t  fmt;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

endpackage

// File: rtl/rv32i_opcodes.sv
// RV32I base opcode map (inst[6:0]).
package rv32i_opcodes;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        MISC_MEM = 7'b0001111,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } rv32i_opcode_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational format classification and sign-extended immediate extraction.
module rv32i_imm_gen
    import rv32i_opcodes::*;
    import rv32i_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output inst_fmt_t       fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        fmt = FmtR;
        case (inst[6:0])
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: fmt = FmtI;
            STORE:                                fmt = FmtS;
            BRANCH:                               fmt = FmtB;
            LUI, AUIPC:                           fmt = FmtU;
            JAL:                                  fmt = FmtJ;
            default:                              fmt = FmtR;
        endcase
    end

    // Replication counts absorb inst[31] so every form stays legal at XLEN == 32.
    always_comb begin
        imm = '0;
        case (fmt)
            FmtI: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            FmtS: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            FmtB: imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            FmtU: imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            FmtJ: imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: legality check, field split, registered output with skid buffer.
module rv32i_decode_stage
    import rv32i_opcodes::*;
    import ALU_FNS::*;
    import LOAD_STORE_FNS::*;
    import rv32i_decode_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_fields_t     f;
    } bundle_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            illegal;
    inst_fmt_t       fmt;
    logic [XLEN-1:0] imm;
    bundle_t         dec_bundle;

    bundle_t main_q, main_d, skid_q, skid_d;
    logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic    accept;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    rv32i_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .inst(in_inst),
        .fmt (fmt),
        .imm (imm)
    );

    always_comb begin
        illegal = 1'b0;
        case (opc)
            OP: begin
                if (f7 == SUB_SRA) begin
                    illegal = !(f3 == ADD_SUB || f3 == SRL_SRA);
                end else begin
                    illegal = (f7 != ADD_SRL);
                end
            end
            OP_IMM: begin
                if (f3 == Funct3Slli) begin
                    illegal = (f7 != 7'd0);
                end else if (f3 == Funct3SrliSrai) begin
                    illegal = !(f7 == ADD_SRL || f7 == SUB_SRA);
                end
            end
            LOAD:   illegal = !(f3 inside {BYTE, HALF, WORD, BYTE_U, HALF_U});
            STORE:  illegal = (f3 > WORD);
            BRANCH: illegal = (f3 == 3'b010 || f3 == 3'b011);
            JALR:   illegal = (f3 != 3'b000);
            LUI, AUIPC, JAL, MISC_MEM, SYSTEM: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_bundle          = '0;
        dec_bundle.pc       = in_pc;
        dec_bundle.imm      = imm;
        dec_bundle.f.opcode = opc;
        dec_bundle.f.rd     = in_inst[11:7];
        dec_bundle.f.rs1    = in_inst[19:15];
        dec_bundle.f.rs2    = in_inst[24:20];
        dec_bundle.f.funct3 = f3;
        dec_bundle.f.funct7 = f7;
        dec_bundle.f.fmt    = fmt;
        dec_bundle.f.illegal = illegal;
        dec_bundle.f.rd_we  = !illegal && (in_inst[11:7] != 5'd0) &&
                              !(opc inside {STORE, BRANCH, MISC_MEM, SYSTEM});
    end

    // With the skid entry, in_ready depends only on flop state, breaking the out_ready path.
    assign in_ready = SKID_EN ? !skid_valid_q : (!main_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec_bundle;
                end
            end
        end else if (accept) begin
            skid_d       = dec_bundle;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_opcode  = main_q.f.opcode;
    assign out_rd      = main_q.f.rd;
    assign out_rs1     = main_q.f.rs1;
    assign out_rs2     = main_q.f.rs2;
    assign out_funct3  = main_q.f.funct3;
    assign out_funct7  = main_q.f.funct7;
    assign out_fmt     = main_q.f.fmt;
    assign out_rd_we   = main_q.f.rd_we;
    assign out_illegal = main_q.f.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed bench for rv32i_decode_stage with a queue-based reference model checked every cycle.
module tb_rv32i_decode_stage;
    import rv32i_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_rd_we;
    logic        out_illegal;

    always #5 clk = ~clk;

    rv32i_decode_stage #(
        .XLEN   (32),
        .SKID_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_fmt    (out_fmt),
        .out_imm    (out_imm),
        .out_rd_we  (out_rd_we),
        .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [2:0]  fmt;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];
    logic [31:0] out_log[$];

    // Reference decode straight from the ISA tables, using signed shifts for immediates.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t               e;
        logic signed [31:0] sw;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic               bad;
        logic               writes;
        sw = w;
        f3 = w[14:12];
        f7 = w[31:25];
        bad = 1'b0;
        writes = 1'b1;
        e = '0;
        e.pc = pc;
        e.opcode = w[6:0];
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.funct3 = f3;
        e.funct7 = f7;
        e.fmt = FmtR;
        case (w[6:0])
            7'h33: bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'h13: begin
                e.fmt = FmtI;
                e.imm = 32'(sw >>> 20);
                if (f3 == 3'd1) bad = (f7 != 7'h00);
                if (f3 == 3'd5) bad = !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'h03: begin
                e.fmt = FmtI;
                e.imm = 32'(sw >>> 20);
                bad = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            7'h67: begin
                e.fmt = FmtI;
                e.imm = 32'(sw >>> 20);
                bad = (f3 != 3'd0);
            end
            7'h73, 7'h0F: begin
                e.fmt = FmtI;
                e.imm = 32'(sw >>> 20);
                writes = 1'b0;
            end
            7'h23: begin
                e.fmt = FmtS;
                e.imm = 32'((sw >>> 25) <<< 5) | 32'(w[11:7]);
                bad = (f3 >= 3'd3);
                writes = 1'b0;
            end
            7'h63: begin
                e.fmt = FmtB;
                e.imm = 32'((sw >>> 31) <<< 12) | (32'(w[7]) << 11) |
                        (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
                bad = (f3 == 3'd2) || (f3 == 3'd3);
                writes = 1'b0;
            end
            7'h37, 7'h17: begin
                e.fmt = FmtU;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.fmt = FmtJ;
                e.imm = 32'((sw >>> 31) <<< 20) | (32'(w[19:12]) << 12) |
                        (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            default: bad = 1'b1;
        endcase
        e.illegal = bad;
        e.rd_we = writes && !bad && (w[11:7] != 5'd0);
        return e;
    endfunction

    function automatic exp_t dut_bundle();
        exp_t g;
        g.pc = out_pc;
        g.imm = out_imm;
        g.opcode = out_opcode;
        g.rd = out_rd;
        g.rs1 = out_rs1;
        g.rs2 = out_rs2;
        g.funct3 = out_funct3;
        g.funct7 = out_funct7;
        g.fmt = out_fmt;
        g.rd_we = out_rd_we;
        g.illegal = out_illegal;
        return g;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Check outputs against the model mid-cycle, then advance the model across the next edge.
    task automatic tick();
        logic acc;
        logic pop;
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        if (q.size() > 0) chk("bundle", 128'(dut_bundle()), 128'(q[0]));
        acc = in_valid && (q.size() < 2) && !flush;
        pop = out_ready && (q.size() > 0);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) begin
                out_log.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (acc) q.push_back(model(in_inst, in_pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst = w;
        in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] words[4];
    int          idx;
    logic        will_acc;

    initial begin
        #2;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset bundle", 128'(dut_bundle()), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(32'hFFF0_0093, 32'h100);
        chk("addi opcode", 128'(out_opcode), 128'(7'h13));
        chk("addi rd/rs1", 128'({out_rd, out_rs1}), 128'({5'd1, 5'd0}));
        chk("addi imm", 128'(out_imm), 128'(32'hFFFF_FFFF));
        chk("addi fmt", 128'(out_fmt), 128'(FmtI));
        chk("addi we/ill", 128'({out_rd_we, out_illegal}), 128'(2'b10));

        send(32'h0020_A423, 32'h104);
        chk("sw opcode", 128'(out_opcode), 128'(7'h23));
        chk("sw rs1/rs2", 128'({out_rs1, out_rs2}), 128'({5'd1, 5'd2}));
        chk("sw funct3", 128'(out_funct3), 128'(3'd2));
        chk("sw imm", 128'(out_imm), 128'(32'd8));
        chk("sw fmt/we", 128'({out_fmt, out_rd_we}), 128'({FmtS, 1'b0}));

        send(32'hFE00_0EE3, 32'h108);
        chk("beq opcode", 128'(out_opcode), 128'(7'h63));
        chk("beq imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        chk("beq fmt", 128'(out_fmt), 128'(FmtB));

        send(32'h0000_0000, 32'h10C);
        chk("zero illegal", 128'({out_valid, out_illegal, out_rd_we}), 128'(3'b110));

        send(32'h4000_7033, 32'h110);
        chk("bad and", 128'({out_valid, out_illegal, out_rd_we}), 128'(3'b110));

        // Extra decode coverage through the model: lui, jal, srai, bad slli, bad load, jalr.
        send(32'hABCD_E0B7, 32'h114);
        chk("lui imm", 128'(out_imm), 128'(32'hABCD_E000));
        send(32'hFFDF_F0EF, 32'h118);
        chk("jal imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        send(32'h4030_D093, 32'h11C);
        send(32'h0200_9093, 32'h120);
        chk("bad slli", 128'(out_illegal), 128'(1));
        send(32'h0000_6083, 32'h124);
        send(32'h0000_80E7, 32'h128);
        tick();

        // Backpressure: four words, sink stalled for three cycles.
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193;
        words[3] = 32'h4020_8233;
        out_log.delete();
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid = (idx < 4);
            if (idx < 4) begin
                in_inst = words[idx];
                in_pc = 32'h200 + 32'(idx) * 4;
            end
            if (cyc == 3) begin
                chk("stall accepted", 128'(idx), 128'(2));
                chk("stall in_ready", 128'(in_ready), 128'(0));
            end
            will_acc = in_valid && (q.size() < 2);
            tick();
            if (will_acc) idx++;
        end
        in_valid = 1'b0;
        chk("stream count", 128'(out_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < out_log.size(); i++) begin
            chk("stream order", 128'(out_log[i]), 128'(32'h200 + 32'(i) * 4));
        end

        // Flush with both entries full and a word offered.
        out_ready = 1'b0;
        send(32'h0050_0293, 32'h300);
        send(32'h0060_0313, 32'h304);
        chk("full in_ready", 128'(in_ready), 128'(0));
        flush = 1'b1;
        in_valid = 1'b1;
        in_inst = 32'h0070_0393;
        in_pc = 32'h308;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", 128'(out_valid), 128'(0));
        chk("flush in_ready", 128'(in_ready), 128'(1));
        tick();

        // Asynchronous reset while a bundle is held.
        send(32'h0080_0413, 32'h400);
        chk("pre-rst valid", 128'(out_valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst out_pc", 128'(out_pc), 128'(0));
        q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick();
        send(32'h0090_0493, 32'h500);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
